// File: rtl/cla_pkg.sv
// Shared definitions for the pipelined carry-lookahead adder.
// Latency: n/a (types, constants and pure combinational helpers only).
// Backpressure: n/a.
// Contents: group/block geometry, the ALU flag struct, the 4-bit group
// propagate/generate function and the 4-wide lookahead carry unit.
package cla_pkg;

   localparam int GROUP_W          = 4;
   localparam int GROUPS_PER_BLOCK = 4;
   localparam int BLOCK_W          = GROUP_W * GROUPS_PER_BLOCK;

   typedef struct packed {
      logic c;
      logic z;
      logic n;
      logic v;
   } alu_flags_t;

   // Collapses four propagate/generate pairs into one {P, G} pair. Used for
   // bits -> group and again for groups -> block.
   function automatic logic [1:0] group_pg(input logic [GROUP_W-1:0] p,
                                           input logic [GROUP_W-1:0] g);
      logic grp_p;
      logic grp_g;
      grp_p = &p;
      grp_g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) |
              (p[3] & p[2] & p[1] & g[0]);
      return {grp_p, grp_g};
   endfunction

   // Lookahead carry unit: carries into positions 0..3 of a 4-wide span.
   // The span's carry-out comes from the level above (group_pg), so only the
   // lower three p/g pairs are needed here.
   function automatic logic [3:0] lookahead_carry(input logic [2:0] p,
                                                  input logic [2:0] g,
                                                  input logic       c_in);
      logic [3:0] c;
      c[0] = c_in;
      c[1] = g[0] | (p[0] & c_in);
      c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_in);
      c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) |
             (p[2] & p[1] & p[0] & c_in);
      return c;
   endfunction

endpackage

// File: rtl/cla_group_pg.sv
// 4-bit group propagate/generate cell for the lookahead adder.
// Latency: combinational.
// Backpressure: none (pure logic).
// Ports: a_i/b_i operand nibbles (b_i already conditionally inverted),
//        p_o bit propagates, grp_p_o/grp_g_o group propagate/generate.
module cla_group_pg
   import cla_pkg::*;
(
   input  logic [GROUP_W-1:0] a_i,
   input  logic [GROUP_W-1:0] b_i,
   output logic [GROUP_W-1:0] p_o,
   output logic               grp_p_o,
   output logic               grp_g_o
);

   logic [GROUP_W-1:0] g;
   logic [1:0]         pg;

   assign p_o              = a_i ^ b_i;
   assign g                = a_i & b_i;
   assign pg               = group_pg(p_o, g);
   assign {grp_p_o, grp_g_o} = pg;

endmodule

// File: rtl/pipelined_cla_adder.sv
// Two-stage pipelined add/subtract with two-level carry lookahead and C/Z/N/V flags.
// Latency: 2 cycles accept-to-out_valid; throughput 1 beat/cycle.
// Backpressure: out_ready low holds the result; stage 1 fills, then in_ready drops.
// Ports: clk, rst (async active-low); in_valid/in_ready/a/b/sub input beat;
//        out_valid/out_ready/sum/c_flag/z_flag/n_flag/v_flag result beat.
// Build option: define CLA_SATURATE_EN to clamp overflowed results to the
// signed max/min instead of wrapping.
module pipelined_cla_adder
   import cla_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             c_flag,
   output logic             z_flag,
   output logic             n_flag,
   output logic             v_flag
);

   localparam int NUM_GRP = WIDTH / GROUP_W;
   localparam int NUM_BLK = WIDTH / BLOCK_W;

   logic               s1_valid_q;
   logic               s2_valid_q;
   logic               s1_adv;
   logic               s2_adv;

   logic [WIDTH-1:0]   a_q;
   logic [WIDTH-1:0]   b_q;
   logic [WIDTH-1:0]   b_d;
   logic               cin_q;

   logic [WIDTH-1:0]   bit_p;
   logic [NUM_GRP-1:0] grp_p;
   logic [NUM_GRP-1:0] grp_g;
   logic [NUM_BLK-1:0] blk_p;
   logic [NUM_BLK-1:0] blk_g;

   logic [WIDTH-1:0]   sum_d;
   logic [WIDTH-1:0]   sum_q;
   alu_flags_t         flags_d;
   alu_flags_t         flags_q;

   // ---------------------------------------------------------------- control
   assign s2_adv   = !s2_valid_q || out_ready;
   assign s1_adv   = !s1_valid_q || s2_adv;
   assign in_ready = s1_adv;

   // Subtract is A + ~B + 1: invert B here and feed sub in as carry-in.
   assign b_d = b ^ {WIDTH{sub}};

   // ---------------------------------------------------------------- stage 1
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_valid_q <= 1'b0;
      end else if (s1_adv) begin
         s1_valid_q <= in_valid;
      end
   end

   always_ff @(posedge clk) begin
      if (s1_adv && in_valid) begin
         a_q   <= a;
         b_q   <= b_d;
         cin_q <= sub;
      end
   end

   genvar gi;
   genvar bi;

   for (gi = 0; gi < NUM_GRP; gi++) begin : g_grp
      cla_group_pg u_group_pg (
         .a_i     (a_q[gi*GROUP_W +: GROUP_W]),
         .b_i     (b_q[gi*GROUP_W +: GROUP_W]),
         .p_o     (bit_p[gi*GROUP_W +: GROUP_W]),
         .grp_p_o (grp_p[gi]),
         .grp_g_o (grp_g[gi])
      );
   end

   for (bi = 0; bi < NUM_BLK; bi++) begin : g_blk
      assign {blk_p[bi], blk_g[bi]} =
         group_pg(grp_p[bi*GROUPS_PER_BLOCK +: GROUPS_PER_BLOCK],
                  grp_g[bi*GROUPS_PER_BLOCK +: GROUPS_PER_BLOCK]);
   end

   // ---------------------------------------------------------------- stage 2 logic
   // Carries resolve top-down: block carry-ins chain across blocks, the
   // lookahead unit spreads each block carry to its groups, then again to bits.
   always_comb begin
      logic [NUM_BLK:0]   blk_c;
      logic [NUM_GRP-1:0] grp_c;
      logic [WIDTH:0]     bit_c;
      logic               ovf;

      blk_c   = '0;
      grp_c   = '0;
      bit_c   = '0;
      ovf     = 1'b0;
      sum_d   = '0;
      flags_d = '0;

      blk_c[0] = cin_q;
      for (int k = 0; k < NUM_BLK; k++) begin
         blk_c[k+1] = blk_g[k] | (blk_p[k] & blk_c[k]);
         grp_c[k*GROUPS_PER_BLOCK +: GROUPS_PER_BLOCK] =
            lookahead_carry(grp_p[k*GROUPS_PER_BLOCK +: 3],
                            grp_g[k*GROUPS_PER_BLOCK +: 3],
                            blk_c[k]);
      end

      // Bit generates are formed locally from the stage-1 operands.
      for (int i = 0; i < NUM_GRP; i++) begin
         bit_c[i*GROUP_W +: GROUP_W] =
            lookahead_carry(bit_p[i*GROUP_W +: 3],
                            a_q[i*GROUP_W +: 3] & b_q[i*GROUP_W +: 3],
                            grp_c[i]);
      end
      bit_c[WIDTH] = blk_c[NUM_BLK];

      ovf   = bit_c[WIDTH] ^ bit_c[WIDTH-1];
      sum_d = bit_p ^ bit_c[WIDTH-1:0];
`ifdef CLA_SATURATE_EN
      // Overflow direction follows A's sign: both operands pushed the same way.
      if (ovf) begin
         sum_d = a_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                              : {1'b0, {(WIDTH-1){1'b1}}};
      end
`endif
      flags_d.c = bit_c[WIDTH];
      flags_d.z = ~|sum_d;
      flags_d.n = sum_d[WIDTH-1];
      flags_d.v = ovf;
   end

   // ---------------------------------------------------------------- stage 2 regs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s2_valid_q <= 1'b0;
         sum_q      <= '0;
         flags_q    <= '0;
      end else if (s2_adv) begin
         s2_valid_q <= s1_valid_q;
         if (s1_valid_q) begin
            sum_q   <= sum_d;
            flags_q <= flags_d;
         end
      end
   end

   assign out_valid = s2_valid_q;
   assign sum       = sum_q;
   assign c_flag    = flags_q.c;
   assign z_flag    = flags_q.z;
   assign n_flag    = flags_q.n;
   assign v_flag    = flags_q.v;

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Self-checking bench for pipelined_cla_adder (WIDTH=32).
// Reference model uses plain integer arithmetic on signed/unsigned values.
module tb_pipelined_cla_adder;

   localparam int W = 32;

   typedef struct packed {
      logic [W-1:0] s;
      logic         c;
      logic         z;
      logic         n;
      logic         v;
   } res_t;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         sub = 1'b0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] sum;
   logic         c_flag, z_flag, n_flag, v_flag;
   res_t         obs;

   int   n_cmp  = 0;
   int   n_fail = 0;
   res_t exp_q[$];
   int   acc_cyc_q[$];

   always #5 clk = ~clk;

   assign obs = {sum, c_flag, z_flag, n_flag, v_flag};

   pipelined_cla_adder #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .c_flag    (c_flag),
      .z_flag    (z_flag),
      .n_flag    (n_flag),
      .v_flag    (v_flag)
   );

   function automatic res_t ref_model(input logic [W-1:0] op_a, input logic [W-1:0] op_b,
                                      input logic op_sub);
      res_t            r;
      longint          sa, sb, sres;
      longint unsigned ua, ub;
      sa = longint'($signed(op_a));
      sb = longint'($signed(op_b));
      ua = {32'd0, op_a};
      ub = {32'd0, op_b};
      if (op_sub) begin
         sres = sa - sb;
         r.c  = (ua >= ub);
         r.s  = op_a - op_b;
      end else begin
         sres = sa + sb;
         r.c  = ((ua + ub) > 64'h0000_0000_FFFF_FFFF);
         r.s  = op_a + op_b;
      end
      r.v = (sres > 64'sh7FFF_FFFF) || (sres < -64'sh8000_0000);
`ifdef CLA_SATURATE_EN
      if (r.v) r.s = (sa >= 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
`endif
      r.z = (r.s == '0);
      r.n = r.s[W-1];
      return r;
   endfunction

   function automatic logic [W-1:0] rand_op();
      case ($urandom_range(0, 5))
         0:       return 32'h0000_0000;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h7FFF_FFFF;
         3:       return 32'h8000_0000;
         default: return $urandom;
      endcase
   endfunction

   task automatic test_reset();
      rst = 1'b1;
      #2 rst = 1'b0;
      #1;
      n_cmp++;
      if (out_valid !== 1'b0) begin
         n_fail++; $display("FAIL reset_out_valid: got %b exp 0", out_valid);
      end
      n_cmp++;
      if (obs !== '0) begin
         n_fail++; $display("FAIL reset_sum_flags: got %h exp 0", obs);
      end
      n_cmp++;
      if (in_ready !== 1'b1) begin
         n_fail++; $display("FAIL reset_in_ready: got %b exp 1", in_ready);
      end
      @(posedge clk);
      #1 rst = 1'b1;
   endtask

   task automatic test_directed();
      logic [W-1:0] ta [7];
      logic [W-1:0] tb_op [7];
      logic         ts [7];
      res_t         te [7];
      ta    = '{32'h5, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h5, 32'h0, 32'h8000_0000, 32'h8000_0000};
      tb_op = '{32'h3, 32'h1,         32'h1,         32'h5, 32'h1, 32'h1,         32'h8000_0000};
      ts    = '{1'b0,  1'b0,          1'b0,          1'b1,  1'b1,  1'b1,          1'b0};
      te[0] = {32'h0000_0008, 4'b0000};
      te[1] = {32'h0000_0000, 4'b1100};
      te[3] = {32'h0000_0000, 4'b1100};
      te[4] = {32'hFFFF_FFFF, 4'b0010};
`ifdef CLA_SATURATE_EN
      te[2] = {32'h7FFF_FFFF, 4'b0001};
      te[5] = {32'h8000_0000, 4'b1011};
      te[6] = {32'h8000_0000, 4'b1011};
`else
      te[2] = {32'h8000_0000, 4'b0011};
      te[5] = {32'h7FFF_FFFF, 4'b1001};
      te[6] = {32'h0000_0000, 4'b1101};
`endif
      out_ready = 1'b1;
      for (int i = 0; i < 7; i++) begin
         @(posedge clk);
         #1 in_valid = 1'b1; a = ta[i]; b = tb_op[i]; sub = ts[i];
         @(negedge clk);
         n_cmp++;
         if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL dir%0d_in_ready: got %b exp 1", i, in_ready);
         end
         @(posedge clk);
         #1 in_valid = 1'b0; a = $urandom; b = $urandom; sub = 1'b0;
         @(negedge clk);
         n_cmp++;
         if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL dir%0d_early_valid: got %b exp 0", i, out_valid);
         end
         @(negedge clk);
         n_cmp++;
         if (out_valid !== 1'b1) begin
            n_fail++; $display("FAIL dir%0d_latency: out_valid got %b exp 1", i, out_valid);
         end
         n_cmp++;
         if (obs !== te[i]) begin
            n_fail++; $display("FAIL dir%0d_result: got %h/%b exp %h/%b",
                               i, obs.s, obs[3:0], te[i].s, te[i][3:0]);
         end
      end
   endtask

   task automatic test_back_to_back();
      int cycle = 0;
      int sent  = 0;
      int got   = 0;
      exp_q.delete();
      acc_cyc_q.delete();
      out_ready = 1'b1;
      while (got < 8 && cycle < 40) begin
         @(posedge clk);
         #1 in_valid = (sent < 8);
         if (in_valid) begin a = $urandom; b = $urandom; sub = 1'($urandom_range(0, 1)); end
         @(negedge clk);
         if (out_valid) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_fail++; $display("FAIL b2b_extra: unexpected result %h", obs.s);
            end else begin
               if (obs !== exp_q[0]) begin
                  n_fail++; $display("FAIL b2b_data: got %h exp %h", obs, exp_q[0]);
               end
               n_cmp++;
               if (cycle !== acc_cyc_q[0] + 2) begin
                  n_fail++; $display("FAIL b2b_latency: out cycle %0d exp %0d", cycle, acc_cyc_q[0] + 2);
               end
               void'(exp_q.pop_front());
               void'(acc_cyc_q.pop_front());
               got++;
            end
         end
         if (in_valid) begin
            n_cmp++;
            if (in_ready !== 1'b1) begin
               n_fail++; $display("FAIL b2b_in_ready: got %b exp 1 at cycle %0d", in_ready, cycle);
            end
            if (in_ready) begin
               exp_q.push_back(ref_model(a, b, sub));
               acc_cyc_q.push_back(cycle);
               sent++;
            end
         end
         cycle++;
      end
      in_valid = 1'b0;
      n_cmp++;
      if (got !== 8) begin
         n_fail++; $display("FAIL b2b_count: got %0d results exp 8", got);
      end
   endtask

   task automatic test_stall();
      int cycle = 0;
      int sent  = 0;
      int got   = 0;
      int stall_acc = 0;
      exp_q.delete();
      while ((sent < 10 || got < 10) && cycle < 60) begin
         @(posedge clk);
         #1 out_ready = (cycle >= 5);
         in_valid = (sent < 10);
         if (in_valid) begin a = $urandom; b = $urandom; sub = 1'($urandom_range(0, 1)); end
         @(negedge clk);
         n_cmp++;
         if (in_ready !== ((exp_q.size() < 2) || out_ready)) begin
            n_fail++; $display("FAIL stall_in_ready: got %b at cycle %0d with %0d in flight",
                               in_ready, cycle, exp_q.size());
         end
         if (out_valid) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_fail++; $display("FAIL stall_dup: unexpected result %h", obs.s);
            end else if (obs !== exp_q[0]) begin
               n_fail++; $display("FAIL stall_data: got %h exp %h at cycle %0d", obs, exp_q[0], cycle);
            end
            if (out_ready && exp_q.size() > 0) begin
               void'(exp_q.pop_front());
               got++;
            end
         end
         if (in_valid && in_ready) begin
            exp_q.push_back(ref_model(a, b, sub));
            sent++;
            if (cycle < 5) stall_acc++;
         end
         cycle++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      n_cmp++;
      if (stall_acc !== 2) begin
         n_fail++; $display("FAIL stall_accepts: got %0d accepted during stall exp 2", stall_acc);
      end
      n_cmp++;
      if (got !== 10 || exp_q.size() !== 0) begin
         n_fail++; $display("FAIL stall_count: got %0d results exp 10, %0d left", got, exp_q.size());
      end
   endtask

   task automatic test_reset_inflight();
      exp_q.delete();
      out_ready = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b1; a = $urandom; b = $urandom; sub = 1'b0;
      @(posedge clk);
      #1 a = $urandom; b = $urandom; sub = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b1) begin
         n_fail++; $display("FAIL rst_pre_valid: got %b exp 1", out_valid);
      end
      #2 rst = 1'b0;
      #1;
      n_cmp++;
      if (out_valid !== 1'b0) begin
         n_fail++; $display("FAIL rst_async_valid: got %b exp 0", out_valid);
      end
      n_cmp++;
      if (obs !== '0) begin
         n_fail++; $display("FAIL rst_async_sum: got %h exp 0", obs);
      end
      @(posedge clk);
      #1 rst = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         n_cmp++;
         if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL rst_stale: out_valid %b exp 0 at cycle %0d after release", out_valid, i);
         end
      end
   endtask

   task automatic test_random();
      int cycle = 0;
      exp_q.delete();
      while (cycle < 300 || (exp_q.size() > 0 && cycle < 340)) begin
         @(posedge clk);
         #1 in_valid = (cycle < 300) && ($urandom_range(0, 9) < 7);
         out_ready = (cycle >= 300) || ($urandom_range(0, 9) < 6);
         a = rand_op(); b = rand_op(); sub = 1'($urandom_range(0, 1));
         @(negedge clk);
         n_cmp++;
         if (in_ready !== ((exp_q.size() < 2) || out_ready)) begin
            n_fail++; $display("FAIL rnd_in_ready: got %b at cycle %0d with %0d in flight",
                               in_ready, cycle, exp_q.size());
         end
         if (out_valid) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_fail++; $display("FAIL rnd_dup: unexpected result %h", obs.s);
            end else if (obs !== exp_q[0]) begin
               n_fail++; $display("FAIL rnd_data: got %h exp %h at cycle %0d", obs, exp_q[0], cycle);
            end
            if (out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
         end
         if (in_valid && in_ready) exp_q.push_back(ref_model(a, b, sub));
         cycle++;
      end
      in_valid = 1'b0;
      n_cmp++;
      if (exp_q.size() !== 0) begin
         n_fail++; $display("FAIL rnd_drain: %0d results never delivered", exp_q.size());
      end
      @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b0) begin
         n_fail++; $display("FAIL rnd_idle: out_valid %b exp 0 after drain", out_valid);
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_back_to_back();
      test_stall();
      test_reset_inflight();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/pipelined_cla_adder.md
Name: pipelined_cla_adder

Overview:
- 2-stage pipelined add/subtract unit for the ALU datapath, built on the team's 4-bit lookahead carry units.
- Stage 1 forms bit, group and block propagate/generate terms from registered operands.
- Stage 2 resolves group carries through two-level lookahead, then produces the sum and the C/Z/N/V flags.
- Valid/ready handshake on both sides so the execute stage can stall it.

Parameters:
- WIDTH, 32, operand width; must be a multiple of 16 (groups of 4 bits, blocks of 4 groups).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  unit can accept a beat this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- sub  in  1  1 = A−B, 0 = A+B.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- sum  out  WIDTH  result.
- c_flag  out  1  carry out of the MSB. For subtract, 1 means no borrow.
- z_flag  out  1  sum == 0.
- n_flag  out  1  sum[WIDTH-1].
- v_flag  out  1  signed overflow, defined as carry into MSB XOR carry out of MSB.

Behaviour:
- Reset (rst low, asynchronous): s1_valid=0, s2_valid=0, out_valid=0, sum=0, all flags=0. Any in-flight beats are discarded. Release of reset is synchronous to clk.
- Input accept: a beat is accepted when in_valid && in_ready.
- Stage 1 capture:
  - Stage 1 registers a, b^{WIDTH{sub}}, and c_in=sub.
  - Per bit: p=a^b', g=a&b'.
  - Per 4-bit group: P=&p, G = lookahead OR of the g terms.
- Stage 2 capture:
  - Group carries are computed by the lookahead carry unit on groups of 4 groups.
  - Block carry-in chains through the block-level lookahead on block P/G.
  - sum = p ^ carries. Flags are computed from the sum and carries and registered together with it.
- Latency: exactly 2 cycles from accept to out_valid with no backpressure. Throughput is 1 beat per cycle.
- Stall rules:
  - s2_adv = !s2_valid || out_ready.
  - s1_adv = !s1_valid || s2_adv.
  - in_ready = s1_adv (combinational, no dependency on in_valid).
- Full pipe with out_ready=1 and in_valid=1: drain, shift and accept all happen in the same cycle; no bubble.
- out_ready=0 with out_valid=1:
  - sum and flags hold stable.
  - Stage 1 holds once it is full, then in_ready drops.
- A stage register loads only when its advance condition is true. Data registers need not reset; valid bits must.
- Arithmetic is modulo 2^WIDTH. Examples:
  - 0xFFFFFFFF+1 gives sum=0, C=1, Z=1.
  - 0x7FFFFFFF+1 gives V=1, N=1.
  - 0−1 gives sum=0xFFFFFFFF, C=0.

Optional Feature:
- Macro: CLA_SATURATE_EN.
- When defined: on V=1 the sum is clamped to 0x7FFF_FFFF if A is non-negative (A as a signed value, i.e. the sign of the overflowed direction), else to 0x8000_0000.
  - V still reports 1.
  - Z and N are recomputed on the clamped value.
  - Latency is unchanged; the clamp sits in stage 2.
- When undefined: the sum wraps, and no clamp logic is present.

Decomposition:
- Package cla_pkg holds:
  - localparam GROUP_W=4.
  - localparam GROUPS_PER_BLOCK=4.
  - typedef alu_flags_t, a struct of c, z, n, v.
  - function to compute group P/G.
- One sub-module, cla_group_pg: takes 4-bit a and b', produces group P, group G and bit-level p.
  - Instantiated WIDTH/4 times in stage 1.
  - Carry resolution reuses the existing lookahead carry unit, with no new carry module.

Test Plan:
- Reset while two beats are in flight (assert rst low between them) -> out_valid=0 immediately. No stale result appears after release.
- 0x0000_0005 + 0x0000_0003, sub=0, out_ready=1 -> 2 cycles later sum=0x8, C=0, Z=0, N=0, V=0.
- 0xFFFF_FFFF + 0x0000_0001 -> sum=0, C=1, Z=1. Then 0x7FFF_FFFF + 1 -> sum=0x8000_0000, N=1, V=1 (0x7FFF_FFFF with CLA_SATURATE_EN).
- sub=1: 5−5 -> sum=0, C=1, Z=1. 0−1 -> sum=0xFFFF_FFFF, C=0, N=1. 0x8000_0000−1 -> V=1.
- Back-to-back 8 beats with out_ready=1 -> 8 results on consecutive cycles, in order, in_ready held at 1.
- out_ready=0 for 5 cycles during the stream -> in_ready falls after 2 accepted beats. The result holds stable. No beat is lost or duplicated after out_ready returns to 1.
